// File: rtl/regfile_access_ctrl.sv
// Arbiter in front of the integer register file. After reset it zero-fills every
// non-zero register, then shares the write port and read port 2 between core and debug.
module regfile_access_ctrl #(
  parameter int REG_DATA_WIDTH = 32,
  parameter int REG_SEL_BITS   = 5,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wb_wEn,
  input  logic [REG_SEL_BITS-1:0]   wb_sel,
  input  logic [REG_DATA_WIDTH-1:0] wb_data,
  input  logic [REG_SEL_BITS-1:0]   core_rs2_sel,
  input  logic                      core_rs2_used,
  input  logic                      dbg_req,
  input  logic                      dbg_we,
  input  logic [REG_SEL_BITS-1:0]   dbg_sel,
  input  logic [REG_DATA_WIDTH-1:0] dbg_wdata,
  output logic                      dbg_ready,
  output logic                      dbg_rvalid,
  output logic [REG_DATA_WIDTH-1:0] dbg_rdata,
  output logic                      rf_wEn,
  output logic [REG_SEL_BITS-1:0]   rf_write_sel,
  output logic [REG_DATA_WIDTH-1:0] rf_write_data,
  output logic [REG_SEL_BITS-1:0]   rf_read_sel2,
  input  logic [REG_DATA_WIDTH-1:0] rf_read_data2,
  output logic                      init_busy,
  output logic                      core_stall
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [REG_SEL_BITS-1:0] LAST_IDX = '1;
  localparam logic [7:0]              LIMIT    = 8'(STARVE_LIMIT);

  state_t                  state, state_next;
  logic [REG_SEL_BITS-1:0] idx;
  logic [7:0]              wait_cnt;
  logic                    core_wr;
  logic                    dbg_wr_grant;
  logic                    dbg_rd_grant;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= INIT;
      idx        <= REG_SEL_BITS'(1);
      wait_cnt   <= '0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) idx <= idx + 1'b1;
      // Counts only cycles in which a live request was refused; any accept or idle clears it.
      if (state == RUN && dbg_req && !dbg_ready) wait_cnt <= wait_cnt + 8'd1;
      else                                       wait_cnt <= '0;
      dbg_rvalid <= dbg_rd_grant;
      if (dbg_rd_grant) dbg_rdata <= rf_read_data2;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    init_busy     = 1'b1;
    core_stall    = 1'b0;
    dbg_ready     = 1'b0;
    core_wr       = 1'b0;
    dbg_wr_grant  = 1'b0;
    dbg_rd_grant  = 1'b0;
    rf_wEn        = 1'b0;
    rf_write_sel  = wb_sel;
    rf_write_data = wb_data;
    rf_read_sel2  = core_rs2_sel;
    if (!reset) begin
      case (state)
        INIT: begin
          rf_wEn        = 1'b1;
          rf_write_sel  = idx;
          rf_write_data = '0;
          if (idx == LAST_IDX) state_next = RUN;
        end
        RUN: begin
          init_busy    = 1'b0;
          core_stall   = (wait_cnt == LIMIT);
          // A forced stall masks the core's port requests so debug wins unconditionally.
          core_wr      = wb_wEn && (wb_sel != '0) && !core_stall;
          dbg_wr_grant = dbg_req && dbg_we && !core_wr;
          dbg_rd_grant = dbg_req && !dbg_we && (!core_rs2_used || core_stall);
          dbg_ready    = dbg_wr_grant || dbg_rd_grant;
          if (core_wr) begin
            rf_wEn = 1'b1;
          end else if (dbg_wr_grant) begin
            rf_wEn        = (dbg_sel != '0);
            rf_write_sel  = dbg_sel;
            rf_write_data = dbg_wdata;
          end
          if (dbg_rd_grant) rf_read_sel2 = dbg_sel;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed test-plan scenarios plus random traffic,
// checked against a cycle-level register-file model and a read-data scoreboard.
module tb_regfile_access_ctrl;

  localparam int W   = 32;
  localparam int SB  = 5;
  localparam int LIM = 8;
  localparam int N   = 1 << SB;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wb_wEn = 1'b0;
  logic [SB-1:0] wb_sel = '0;
  logic [W-1:0]  wb_data = '0;
  logic [SB-1:0] core_rs2_sel = '0;
  logic          core_rs2_used = 1'b0;
  logic          dbg_req = 1'b0;
  logic          dbg_we = 1'b0;
  logic [SB-1:0] dbg_sel = '0;
  logic [W-1:0]  dbg_wdata = '0;
  logic          dbg_ready, dbg_rvalid, rf_wEn, init_busy, core_stall;
  logic [W-1:0]  dbg_rdata, rf_write_data, rf_read_data2;
  logic [SB-1:0] rf_write_sel, rf_read_sel2;

  regfile_access_ctrl #(.REG_DATA_WIDTH(W), .REG_SEL_BITS(SB), .STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset),
    .wb_wEn(wb_wEn), .wb_sel(wb_sel), .wb_data(wb_data),
    .core_rs2_sel(core_rs2_sel), .core_rs2_used(core_rs2_used),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_sel(dbg_sel), .dbg_wdata(dbg_wdata),
    .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .rf_wEn(rf_wEn), .rf_write_sel(rf_write_sel), .rf_write_data(rf_write_data),
    .rf_read_sel2(rf_read_sel2), .rf_read_data2(rf_read_data2),
    .init_busy(init_busy), .core_stall(core_stall)
  );

  always #5 clock = ~clock;

  // Environment register file, driven only by the DUT's write port; x0 reads as zero.
  logic [W-1:0] env_rf [N];
  assign rf_read_data2 = (rf_read_sel2 == '0) ? '0 : env_rf[rf_read_sel2];

  initial begin
    for (int i = 0; i < N; i++) env_rf[i] = $urandom;
    forever begin
      @(posedge clock);
      if (rf_wEn === 1'b1) env_rf[rf_write_sel] <= rf_write_data;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: expected register contents and arbitration bookkeeping.
  logic [W-1:0] m_regs [N];
  logic [W-1:0] exp_q [$];
  bit           m_init = 1'b1;
  int           m_idx = 1;
  int           m_blocked = 0;
  bit           m_rv = 1'b0;
  bit           m_after_rst = 1'b0;
  bit           m_grant = 1'b0;

  task automatic step(input bit rst, input bit wbe, input logic [SB-1:0] wbs, input logic [W-1:0] wbd,
                      input logic [SB-1:0] rs2s, input bit rs2u, input bit rq, input bit we,
                      input logic [SB-1:0] ds, input logic [W-1:0] dwd);
    bit            e_ready, e_stall, e_wen, core_wins, rd_ok;
    logic [SB-1:0] e_wsel, e_rsel;
    logic [W-1:0]  e_wdata;
    @(negedge clock);
    reset = rst; wb_wEn = wbe; wb_sel = wbs; wb_data = wbd;
    core_rs2_sel = rs2s; core_rs2_used = rs2u;
    dbg_req = rq; dbg_we = we; dbg_sel = ds; dbg_wdata = dwd;
    #1;
    e_ready = 1'b0; e_wen = 1'b0; rd_ok = 1'b0; e_wsel = '0; e_wdata = '0;
    if (!rst) check("dbg_rvalid", dbg_rvalid, m_rv);
    if (!rst && m_after_rst) check("dbg_rdata_after_reset", dbg_rdata, '0);
    if (rst) begin
      check("rst_rf_wEn", rf_wEn, 0);
      check("rst_dbg_ready", dbg_ready, 0);
      check("rst_core_stall", core_stall, 0);
      check("rst_init_busy", init_busy, 1);
      m_init = 1'b1; m_idx = 1; m_blocked = 0;
    end else if (m_init) begin
      check("init_busy", init_busy, 1);
      check("init_dbg_ready", dbg_ready, 0);
      check("init_core_stall", core_stall, 0);
      check("init_rf_wEn", rf_wEn, 1);
      check("init_write_sel", rf_write_sel, W'(m_idx));
      check("init_write_data", rf_write_data, '0);
      m_regs[m_idx] = '0;
      if (m_idx == N - 1) m_init = 1'b0;
      m_idx++;
    end else begin
      // A request refused LIM times in a row forces the stall and is then served.
      e_stall   = (m_blocked == LIM);
      core_wins = wbe && (wbs != 0) && !e_stall;
      if (rq && we)  e_ready = !core_wins;
      if (rq && !we) begin e_ready = !rs2u || e_stall; rd_ok = e_ready; end
      if (core_wins) begin
        e_wen = 1'b1; e_wsel = wbs; e_wdata = wbd;
      end else if (rq && we && ds != 0) begin
        e_wen = 1'b1; e_wsel = ds; e_wdata = dwd;
      end
      e_rsel = rd_ok ? ds : rs2s;
      check("run_init_busy", init_busy, 0);
      check("dbg_ready", dbg_ready, e_ready);
      check("core_stall", core_stall, e_stall);
      check("rf_wEn", rf_wEn, e_wen);
      if (e_wen) begin
        check("rf_write_sel", rf_write_sel, W'(e_wsel));
        check("rf_write_data", rf_write_data, e_wdata);
      end
      check("rf_read_sel2", rf_read_sel2, W'(e_rsel));
      if (rd_ok) exp_q.push_back((ds == 0) ? '0 : m_regs[ds]);
      if (e_wen) m_regs[e_wsel] = e_wdata;
      m_blocked = (rq && !e_ready) ? m_blocked + 1 : 0;
    end
    m_rv        = rd_ok;
    m_after_rst = rst;
    m_grant     = e_ready;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  // Read-data monitor: every rvalid pulse consumes one expected value.
  initial begin
    logic [W-1:0] exp;
    forever begin
      @(negedge clock);
      if (dbg_rvalid === 1'b1) begin
        if (exp_q.size() == 0) check("rvalid_unexpected", 1, 0);
        else begin
          exp = exp_q.pop_front();
          check("scoreboard_rdata", dbg_rdata, exp);
        end
      end
    end
  end

  initial begin
    int           n;
    bit           rst, pend, p_we;
    logic [SB-1:0] p_sel;
    logic [W-1:0]  p_wd;
    for (int i = 0; i < N; i++) m_regs[i] = '0;

    step(1, 0, '0, '0, '0, 0, 0, 0, '0, '0);
    step(1, 0, '0, '0, '0, 0, 0, 0, '0, '0);
    idle(N - 1);
    check("sweep_done", W'(m_init), 0);
    idle(1);

    // Core writeback beats a pending debug write, which lands the following cycle.
    step(0, 1, 5'd5, 32'hAAAA5555, '0, 0, 1, 1, 5'd6, 32'h1234);
    step(0, 0, '0, '0, '0, 0, 1, 1, 5'd6, 32'h1234);
    // Debug write to x0 is accepted but dropped; reading x0 gives zero.
    step(0, 0, '0, '0, '0, 0, 1, 1, 5'd0, 32'hFFFFFFFF);
    step(0, 0, '0, '0, '0, 0, 1, 0, 5'd0, '0);
    step(0, 0, '0, '0, '0, 0, 1, 0, 5'd6, '0);
    idle(2);

    n = 0;
    do begin step(0, 0, '0, '0, 5'd3, 1, 1, 0, 5'd5, '0); n++; end while (!m_grant && n < LIM + 4);
    check("starve_read_latency", n, LIM + 1);
    idle(1);

    n = 0;
    do begin step(0, 1, 5'd7, $urandom, '0, 0, 1, 1, 5'd9, 32'hCAFE0009); n++; end
    while (!m_grant && n < LIM + 4);
    check("starve_write_latency", n, LIM + 1);
    step(0, 0, '0, '0, '0, 0, 1, 0, 5'd9, '0);
    idle(2);

    pend = 1'b0; p_we = 1'b0; p_sel = '0; p_wd = '0;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1'b1; p_we = 1'($urandom_range(0, 1)); p_sel = SB'($urandom); p_wd = $urandom;
      end
      step(rst, $urandom_range(0, 2) != 0, SB'($urandom), $urandom, SB'($urandom),
           $urandom_range(0, 3) != 0, pend, p_we, p_sel, p_wd);
      if (rst || m_grant) pend = 1'b0;
    end
    idle(2);

    // Reset in the middle of the sweep, then again while a debug read is starving.
    step(1, 0, '0, '0, '0, 0, 0, 0, '0, '0);
    n = 0;
    while (m_idx != 17 && n < 40) begin idle(1); n++; end
    check("reached_idx17", m_idx, 17);
    step(1, 0, '0, '0, '0, 0, 0, 0, '0, '0);
    idle(N - 1);
    for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 5'd2, 1, 1, 0, 5'd4, '0);
    step(1, 0, '0, '0, 5'd2, 1, 1, 0, 5'd4, '0);
    n = 0;
    do begin step(0, 0, '0, '0, 5'd2, 1, 1, 0, 5'd4, '0); n++; end
    while (!m_grant && n < N + LIM + 4);
    check("post_reset_latency", n, (N - 1) + LIM + 1);
    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
